// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI refill bridge.
// On a cache miss this block optionally writes the dirty victim line back over
// an AXI write burst, then fetches the missing line over an AXI read burst and
// hands it to the cache with a one-cycle refresh pulse.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   miss, write_back    line-fill request and dirty-victim flag (level)
//   raddr, waddr        line-aligned fill and victim addresses
//   cacheline_old       victim line data
//   refresh             one-cycle pulse, cacheline_new holds the filled line
//   cacheline_new       filled line
//   ar*/r*              AXI read address / read data channels (32-bit beats)
//   aw*/w*/b*           AXI write address / write data / write response channels
module cache_axi_bridge #(
    parameter int unsigned CACHELINE_WD = 512
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    miss,
    input  logic                    write_back,
    input  logic [31:0]             raddr,
    input  logic [31:0]             waddr,
    input  logic [CACHELINE_WD-1:0] cacheline_old,
    output logic                    refresh,
    output logic [CACHELINE_WD-1:0] cacheline_new,

    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,

    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             wdata,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int unsigned WORDS = CACHELINE_WD / 32;
    localparam int unsigned CNT_WD = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_WD-1:0] LAST_BEAT = CNT_WD'(WORDS - 1);
    localparam logic [CNT_WD-1:0] ONE = CNT_WD'(1);

    typedef enum logic [2:0] {
        StIdle, StWbAw, StWbW, StWbB, StRdAr, StRdR, StRefill, StCool
    } state_t;

    state_t                  state;
    logic [CNT_WD-1:0]       beat;
    logic [CACHELINE_WD-1:0] wbuf;     // victim line, shifted down one beat per W transfer
    logic                    b_done;   // write response taken, turnaround before AR

    assign wdata = wbuf[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= StIdle;
            beat          <= '0;
            wbuf          <= '0;
            b_done        <= 1'b0;
            arvalid       <= 1'b0;
            araddr        <= '0;
            rready        <= 1'b0;
            awvalid       <= 1'b0;
            awaddr        <= '0;
            wvalid        <= 1'b0;
            wlast         <= 1'b0;
            bready        <= 1'b0;
            refresh       <= 1'b0;
            cacheline_new <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (miss) begin
                        // Request is snapshotted here; inputs are ignored until back in idle.
                        araddr <= raddr;
                        awaddr <= waddr;
                        wbuf   <= cacheline_old;
                        if (write_back) begin
                            awvalid <= 1'b1;
                            state   <= StWbAw;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= StRdAr;
                        end
                    end
                end
                StWbAw: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= (WORDS == 1);
                        beat    <= '0;
                        state   <= StWbW;
                    end
                end
                StWbW: begin
                    if (wready) begin
                        if (beat == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            b_done <= 1'b0;
                            state  <= StWbB;
                        end else begin
                            beat  <= beat + ONE;
                            wbuf  <= wbuf >> 32;
                            wlast <= (beat + ONE == LAST_BEAT);
                        end
                    end
                end
                StWbB: begin
                    // One turnaround cycle after the response so the read address
                    // never shares an edge with write completion.
                    if (b_done) begin
                        b_done  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= StRdAr;
                    end else if (bvalid) begin
                        bready <= 1'b0;
                        b_done <= 1'b1;
                    end
                end
                StRdAr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat    <= '0;
                        state   <= StRdR;
                    end
                end
                StRdR: begin
                    if (rvalid) begin
                        cacheline_new[32*beat +: 32] <= rdata;
                        if (beat == LAST_BEAT) begin
                            rready  <= 1'b0;
                            refresh <= 1'b1;
                            state   <= StRefill;
                        end else begin
                            beat <= beat + ONE;
                        end
                    end
                end
                StRefill: begin
                    refresh <= 1'b0;
                    state   <= StCool;
                end
                StCool: begin
                    // Cache is still dropping miss this cycle; do not sample it.
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;

    localparam int LW = 512;
    localparam int W  = LW / 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          miss = 1'b0;
    logic          write_back = 1'b0;
    logic [31:0]   raddr = '0;
    logic [31:0]   waddr = '0;
    logic [LW-1:0] cacheline_old = '0;
    logic          refresh;
    logic [LW-1:0] cacheline_new;
    logic          arvalid, rready, awvalid, wvalid, wlast, bready;
    logic          arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]   araddr, awaddr, wdata;
    logic [31:0]   rdata = '0;

    cache_axi_bridge #(.CACHELINE_WD(LW)) dut (
        .clk(clk), .rst(rst),
        .miss(miss), .write_back(write_back), .raddr(raddr), .waddr(waddr),
        .cacheline_old(cacheline_old), .refresh(refresh), .cacheline_new(cacheline_new),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave/monitor state, updated once per falling edge.
    int            cyc = 0;
    bit            stall_en = 0;
    bit            spurious = 0;
    bit            rd_active = 0, b_active = 0, wr_open = 0;
    int            rd_beat = 0, wr_beat = 0;
    logic [31:0]   rd_base = '0, aw_addr_seen = '0;
    int            ar_cnt = 0, aw_cnt = 0, rd_cnt = 0, b_cnt = 0, refresh_cnt = 0;
    int            refresh_cyc = 0, b_cyc = 0, ar_first_cyc = 0;
    int            order_viol = 0, stab_viol = 0;
    logic [LW-1:0] line_at_refresh = '0, wlog = '0;
    logic [W-1:0]  wlast_log = '0;
    bit            prev_arvalid = 0, prev_ar_stall = 0, prev_aw_stall = 0, prev_w_stall = 0;
    logic [31:0]   prev_araddr = '0, prev_awaddr = '0, prev_wdata = '0;
    logic          prev_wlast = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                rd_active = 0; b_active = 0; wr_open = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                prev_arvalid = 0; prev_ar_stall = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                if (prev_ar_stall && (!arvalid || araddr !== prev_araddr)) stab_viol++;
                if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) stab_viol++;
                if (prev_w_stall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast))
                    stab_viol++;
                if (arvalid && wr_open) order_viol++;
                if (arvalid && !prev_arvalid) ar_first_cyc = cyc;
                if (refresh) begin
                    refresh_cnt++;
                    refresh_cyc = cyc;
                    line_at_refresh = cacheline_new;
                end
                // R channel
                rvalid = spurious || (rd_active && !(stall_en && $urandom_range(0, 1) == 1));
                rdata  = rd_base + 32'(rd_beat);
                if (rvalid && rready) begin
                    rd_cnt++;
                    if (rd_active) begin
                        if (rd_beat == W - 1) rd_active = 0;
                        else rd_beat++;
                    end
                end
                // B channel
                bvalid = spurious || (b_active && !(stall_en && $urandom_range(0, 1) == 1));
                if (bvalid && bready) begin
                    b_cnt++;
                    b_active = 0;
                    wr_open = 0;
                    b_cyc = cyc;
                end
                // AR channel
                arready = !(stall_en && $urandom_range(0, 1) == 1);
                if (arvalid && arready) begin
                    ar_cnt++;
                    rd_active = 1;
                    rd_beat = 0;
                    rd_base = araddr;
                end
                // AW channel
                awready = !(stall_en && $urandom_range(0, 1) == 1);
                if (awvalid && awready) begin
                    aw_cnt++;
                    aw_addr_seen = awaddr;
                    wr_open = 1;
                    wr_beat = 0;
                    wlog = '0;
                    wlast_log = '0;
                end
                // W channel
                wready = !(stall_en && $urandom_range(0, 1) == 1);
                if (wvalid && wready) begin
                    if (wr_beat < W) begin
                        wlog[32*wr_beat +: 32] = wdata;
                        wlast_log[wr_beat] = wlast;
                    end
                    if (wlast) b_active = 1;
                    wr_beat++;
                end
                prev_arvalid  = arvalid;
                prev_ar_stall = arvalid && !arready;
                prev_araddr   = araddr;
                prev_aw_stall = awvalid && !awready;
                prev_awaddr   = awaddr;
                prev_w_stall  = wvalid && !wready;
                prev_wdata    = wdata;
                prev_wlast    = wlast;
            end
        end
    end

    int t0 = 0;
    int r0 = 0;

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic start_miss(input bit wb, input logic [31:0] ra, input logic [31:0] wa,
                              input logic [31:0] old_base);
        step();
        write_back = wb;
        raddr = ra;
        waddr = wa;
        for (int i = 0; i < W; i++) cacheline_old[32*i +: 32] = old_base + 32'(i);
        miss = 1'b1;
        t0 = cyc;
        r0 = refresh_cnt;
        step();
        // Scramble request inputs; the bridge must use its snapshot.
        raddr = ~ra;
        waddr = ~wa;
        cacheline_old = ~cacheline_old;
        write_back = ~wb;
    endtask

    task automatic wait_refresh(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (refresh_cnt != r0) seen = 1;
            else step();
        end
        if (refresh_cnt != r0) seen = 1;
    endtask

    function automatic logic [LW-1:0] ramp(input logic [31:0] base);
        logic [LW-1:0] v;
        for (int i = 0; i < W; i++) v[32*i +: 32] = base + 32'(i);
        return v;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({refresh, arvalid, awvalid, wvalid, wlast, rready, bready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {refresh, arvalid, awvalid, wvalid, wlast, rready, bready});
        end
        checks++;
        if ({araddr, awaddr, wdata} !== 96'b0) begin
            errors++;
            $display("FAIL reset_addr: got %h %h %h expected 0", araddr, awaddr, wdata);
        end
        checks++;
        if (cacheline_new !== '0) begin
            errors++;
            $display("FAIL reset_line: got %h expected 0", cacheline_new);
        end
        step();
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic test_clean_miss();
        bit seen;
        int a0 = aw_cnt;
        start_miss(1'b0, 32'h0000_1000, 32'h0000_7000, 32'h0);
        wait_refresh(200, seen);
        miss = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL clean_timeout: got no refresh expected refresh"); end
        checks++;
        if (refresh_cyc - t0 != W + 2) begin
            errors++;
            $display("FAIL clean_latency: got %0d expected %0d", refresh_cyc - t0, W + 2);
        end
        checks++;
        if (rd_base !== 32'h1000) begin
            errors++;
            $display("FAIL clean_araddr: got %h expected %h", rd_base, 32'h1000);
        end
        checks++;
        if (line_at_refresh !== ramp(32'h1000)) begin
            errors++;
            $display("FAIL clean_line: got %h expected %h", line_at_refresh, ramp(32'h1000));
        end
        checks++;
        if (aw_cnt != a0) begin
            errors++;
            $display("FAIL clean_no_write: got %0d aw expected %0d", aw_cnt - a0, 0);
        end
        repeat (3) step();
    endtask

    task automatic test_dirty_miss();
        bit seen;
        start_miss(1'b1, 32'h0000_3000, 32'h0000_2000, 32'hA0);
        wait_refresh(200, seen);
        miss = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL dirty_timeout: got no refresh expected refresh"); end
        checks++;
        if (refresh_cyc - t0 != 2 * W + 5) begin
            errors++;
            $display("FAIL dirty_latency: got %0d expected %0d", refresh_cyc - t0, 2 * W + 5);
        end
        checks++;
        if (aw_addr_seen !== 32'h2000) begin
            errors++;
            $display("FAIL dirty_awaddr: got %h expected %h", aw_addr_seen, 32'h2000);
        end
        checks++;
        if (wlog !== ramp(32'hA0)) begin
            errors++;
            $display("FAIL dirty_wdata: got %h expected %h", wlog, ramp(32'hA0));
        end
        checks++;
        if (wlast_log !== (W'(1) << (W - 1))) begin
            errors++;
            $display("FAIL dirty_wlast: got %b expected %b", wlast_log, W'(1) << (W - 1));
        end
        checks++;
        if (!(ar_first_cyc > b_cyc) || order_viol != 0) begin
            errors++;
            $display("FAIL dirty_order: got ar@%0d b@%0d viol %0d expected ar after b, 0 viol",
                     ar_first_cyc, b_cyc, order_viol);
        end
        checks++;
        if (line_at_refresh !== ramp(32'h3000)) begin
            errors++;
            $display("FAIL dirty_line: got %h expected %h", line_at_refresh, ramp(32'h3000));
        end
        repeat (3) step();
    endtask

    task automatic test_wait_states();
        bit seen;
        stall_en = 1;
        start_miss(1'b1, 32'h0000_1000, 32'h0000_2000, 32'hA0);
        wait_refresh(2000, seen);
        miss = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_dirty_timeout: got no refresh expected refresh"); end
        checks++;
        if (line_at_refresh !== ramp(32'h1000) || wlog !== ramp(32'hA0)) begin
            errors++;
            $display("FAIL stall_dirty_data: got %h / %h expected %h / %h",
                     line_at_refresh, wlog, ramp(32'h1000), ramp(32'hA0));
        end
        repeat (3) step();
        start_miss(1'b0, 32'h0000_1000, 32'h0, 32'h0);
        wait_refresh(2000, seen);
        miss = 1'b0;
        checks++;
        if (!seen || line_at_refresh !== ramp(32'h1000)) begin
            errors++;
            $display("FAIL stall_clean_line: got %h expected %h", line_at_refresh, ramp(32'h1000));
        end
        checks++;
        if (stab_viol != 0 || order_viol != 0) begin
            errors++;
            $display("FAIL stall_stability: got %0d/%0d violations expected 0/0",
                     stab_viol, order_viol);
        end
        stall_en = 0;
        repeat (3) step();
    endtask

    task automatic test_miss_held();
        bit seen;
        int a1;
        start_miss(1'b0, 32'h0000_4000, 32'h0, 32'h0);
        wait_refresh(200, seen);
        a1 = ar_cnt;
        step();
        checks++;
        if (arvalid !== 1'b0 || refresh !== 1'b0) begin
            errors++;
            $display("FAIL held_cool: got arvalid %b refresh %b expected 0 0", arvalid, refresh);
        end
        miss = 1'b0;
        repeat (5) step();
        checks++;
        if (refresh_cnt != r0 + 1 || ar_cnt != a1) begin
            errors++;
            $display("FAIL held_single: got %0d refresh %0d ar expected 1 refresh 0 ar",
                     refresh_cnt - r0, ar_cnt - a1);
        end
    endtask

    task automatic test_extra_beats();
        int rc = rd_cnt;
        int bc = b_cnt;
        int fr = refresh_cnt;
        spurious = 1;
        repeat (5) step();
        checks++;
        if (rready !== 1'b0 || bready !== 1'b0) begin
            errors++;
            $display("FAIL extra_ready: got rready %b bready %b expected 0 0", rready, bready);
        end
        spurious = 0;
        step();
        checks++;
        if (rd_cnt != rc || b_cnt != bc || refresh_cnt != fr) begin
            errors++;
            $display("FAIL extra_accepted: got r %0d b %0d refresh %0d expected 0 0 0",
                     rd_cnt - rc, b_cnt - bc, refresh_cnt - fr);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        int rc;
        int fr;
        start_miss(1'b0, 32'h0000_5000, 32'h0, 32'h0);
        rc = rd_cnt;
        for (int i = 0; i < 100 && rd_cnt - rc < 5; i++) step();
        fr = refresh_cnt;
        rst = 1'b0;
        #1;
        checks++;
        if ({refresh, arvalid, awvalid, wvalid, wlast, rready, bready} !== 7'b0 ||
            araddr !== 32'h0 || cacheline_new !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got ctrl %b araddr %h line %h expected 0",
                     {refresh, arvalid, awvalid, wvalid, wlast, rready, bready}, araddr,
                     cacheline_new);
        end
        miss = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (refresh_cnt != fr) begin
            errors++;
            $display("FAIL midreset_no_refresh: got %0d expected 0", refresh_cnt - fr);
        end
        start_miss(1'b0, 32'h0000_6000, 32'h0, 32'h0);
        wait_refresh(200, seen);
        miss = 1'b0;
        checks++;
        if (!seen || refresh_cyc - t0 != W + 2 || line_at_refresh !== ramp(32'h6000)) begin
            errors++;
            $display("FAIL midreset_restart: got lat %0d line %h expected lat %0d line %h",
                     refresh_cyc - t0, line_at_refresh, W + 2, ramp(32'h6000));
        end
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_miss_held();
        test_extra_beats();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter CACHELINE_WD, default 512, cache line width in bits; WORDS = CACHELINE_WD/32 beats per line.
REQ-002 SHALL have clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have miss  input  1  cache requests a line fill; level, held until refresh.
REQ-005 SHALL have write_back  input  1  victim line is dirty; valid with miss.
REQ-006 SHALL have raddr  input  32  line-aligned fill address.
REQ-007 SHALL have waddr  input  32  line-aligned victim address.
REQ-008 SHALL have cacheline_old  input  CACHELINE_WD  victim line data.
REQ-009 SHALL have refresh  output  1  one-cycle pulse: cacheline_new valid, cache installs line.
REQ-010 SHALL have cacheline_new  output  CACHELINE_WD  filled line.
REQ-011 SHALL have arvalid/arready  output/input  1/1  read-address handshake; araddr  output  32.
REQ-012 SHALL have rvalid/rready  input/output  1/1  read-data handshake; rdata  input  32.
REQ-013 SHALL have awvalid/awready  output/input  1/1  write-address handshake; awaddr  output  32.
REQ-014 SHALL have wvalid/wready  output/input  1/1  write-data handshake; wdata  output  32; wlast  output  1.
REQ-015 SHALL have bvalid/bready  input/output  1/1  write-response handshake.

Function
REQ-016 SHALL implement FSM IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, COOL.
REQ-017 In IDLE with miss=1: SHALL go to WB_AW if write_back=1, else RD_AR; raddr, waddr, cacheline_old captured that cycle; later input changes ignored until IDLE.
REQ-018 Bursts SHALL be fixed length WORDS, incrementing, 32-bit beats; beat i carries bits [32i+31:32i] of the line.
REQ-019 A transfer SHALL occur only on a cycle where valid and ready are both 1; valid, once raised, SHALL stay high with stable address/data until the transfer.
REQ-020 WB_AW: awvalid=1, awaddr=captured waddr; on handshake -> WB_W.
REQ-021 WB_W: wvalid=1, wdata=current beat, wlast=1 only on beat WORDS-1; on last handshake -> WB_B.
REQ-022 WB_B: bready=1; on bvalid -> RD_AR; response code ignored.
REQ-023 RD_AR: arvalid=1, araddr=captured raddr; on handshake -> RD_R.
REQ-024 RD_R: rready=1; each accepted beat written into cacheline_new slot of beat counter; after beat WORDS-1 -> REFILL.
REQ-025 REFILL: refresh=1 for exactly one cycle, cacheline_new complete and stable; -> COOL.
REQ-026 COOL: one idle cycle, miss ignored (cache drops miss after refresh); -> IDLE.
REQ-027 Minimum latency, miss to refresh, all ready/valid at 1: clean = WORDS+2 cycles, dirty = 2*WORDS+5 cycles.
REQ-028 Beat counter SHALL be log2(WORDS) bits, cleared on each burst start, no wrap past WORDS-1.
REQ-029 Extra rvalid or bvalid beats outside RD_R/WB_B SHALL not be accepted (ready=0).
REQ-030 At most one read and one write burst outstanding; the write burst SHALL complete (bvalid) before the read address is issued.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, counters 0, all valid/ready/refresh/wlast 0, addresses 0, cacheline_new 0; reset mid-burst abandons the burst, no refresh.

Verification
REQ-032 Clean miss raddr=0x0000_1000, memory returns 0x1000+i per beat, zero wait -> araddr=0x1000, refresh at cycle WORDS+2, cacheline_new word i = 0x1000+i.
REQ-033 Dirty miss waddr=0x2000, cacheline_old word i=0xA0+i -> awaddr=0x2000, wdata sequence 0xA0..0xA0+WORDS-1, wlast on beat WORDS-1, arvalid only after bvalid.
REQ-034 Random wait states on arready/rvalid/awready/wready/bvalid -> valid and payload held stable while stalled; line data identical to zero-wait case.
REQ-035 miss held high through refresh -> exactly one refresh pulse, no second arvalid in COOL.
REQ-036 rst=0 asserted at read beat 5 -> all outputs 0 immediately; next miss restarts with beat counter 0 and correct line.
